watch_button_controller: RTL

//  Front-panel input stage feeding smartwatch: turns three raw pushbuttons into the

---
 rtl/watch_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 45 ++++
 rtl/watch_button_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared constants and helpers for the smartwatch front-panel controller.
package watch_pkg;

    localparam int unsigned MODE_W          = 3;
    localparam int unsigned HOUR_W          = 5;
    localparam int unsigned MIN_W           = 6;
    localparam int unsigned SEC_W           = 6;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned DB_CNT_W        = 3;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] SET_HR  = 3'd1;
    localparam logic [2:0] SET_MIN = 3'd2;
    localparam logic [2:0] SET_SEC = 3'd3;
    localparam logic [2:0] ALM_HR  = 3'd4;
    localparam logic [2:0] ALM_MIN = 3'd5;

    // Up/down step with wrap-around between 0 and max; up has no priority issue
    // because callers never assert both.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                             input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up)
            r = (v == max) ? 6'd0 : v + 6'd1;
        else if (dn)
            r = (v == 6'd0) ? max : v - 6'd1;
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse for one button.
module button_debouncer
    import watch_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W  = DB_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/watch_button_controller.sv
// Front-panel input stage: debounced buttons drive the mode FSM, time/alarm
// setting registers and stopwatch controls.
module watch_button_controller
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [2:0] mode,
    output logic [4:0] hours_initial,
    output logic [5:0] minutes_initial,
    output logic [5:0] seconds_initial,
    output logic       load_time,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       start_stopwatch,
    output logic       reset_stopwatch
);

    logic mode_press;
    logic inc_press;
    logic dec_press;
    logic up;
    logic dn;

    logic [2:0] state_next;
    logic [4:0] hours_next;
    logic [5:0] minutes_next;
    logic [5:0] seconds_next;
    logic [4:0] alarm_hours_next;
    logic [5:0] alarm_minutes_next;
    logic       load_next;
    logic       start_next;
    logic       clear_next;

    button_debouncer u_db_mode (.clk(clk), .reset(reset), .btn(btn_mode), .press(mode_press));
    button_debouncer u_db_inc  (.clk(clk), .reset(reset), .btn(btn_inc),  .press(inc_press));
    button_debouncer u_db_dec  (.clk(clk), .reset(reset), .btn(btn_dec),  .press(dec_press));

    // A mode press masks edits; inc and dec together cancel.
    assign up = inc_press & ~dec_press & ~mode_press;
    assign dn = dec_press & ~inc_press & ~mode_press;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode            <= RUN;
            hours_initial   <= '0;
            minutes_initial <= '0;
            seconds_initial <= '0;
            alarm_hours     <= '0;
            alarm_minutes   <= '0;
            load_time       <= 1'b0;
            start_stopwatch <= 1'b0;
            reset_stopwatch <= 1'b0;
        end else begin
            mode            <= state_next;
            hours_initial   <= hours_next;
            minutes_initial <= minutes_next;
            seconds_initial <= seconds_next;
            alarm_hours     <= alarm_hours_next;
            alarm_minutes   <= alarm_minutes_next;
            load_time       <= load_next;
            start_stopwatch <= start_next;
            reset_stopwatch <= clear_next;
        end
    end

    always_comb begin
        state_next         = mode;
        hours_next         = hours_initial;
        minutes_next       = minutes_initial;
        seconds_next       = seconds_initial;
        alarm_hours_next   = alarm_hours;
        alarm_minutes_next = alarm_minutes;
        load_next          = 1'b0;
        start_next         = start_stopwatch;
        clear_next         = 1'b0;

        if (mode_press) begin
            case (mode)
                RUN:     state_next = SET_HR;
                SET_HR:  state_next = SET_MIN;
                SET_MIN: state_next = SET_SEC;
                SET_SEC: begin
                    state_next = ALM_HR;
                    load_next  = 1'b1;
                end
                ALM_HR:  state_next = ALM_MIN;
                default: state_next = RUN;
            endcase
        end else begin
            case (mode)
                RUN: begin
                    if (up)
                        start_next = ~start_stopwatch;
                    if (dn) begin
                        start_next = 1'b0;
                        clear_next = 1'b1;
                    end
                end
                SET_HR:  hours_next = HOUR_W'(wrap_step(6'(hours_initial), 6'(HOUR_MAX), up, dn));
                SET_MIN: minutes_next = wrap_step(minutes_initial, 6'(MIN_MAX), up, dn);
                SET_SEC: seconds_next = wrap_step(seconds_initial, 6'(SEC_MAX), up, dn);
                ALM_HR:  alarm_hours_next = HOUR_W'(wrap_step(6'(alarm_hours), 6'(HOUR_MAX), up, dn));
                ALM_MIN: alarm_minutes_next = wrap_step(alarm_minutes, 6'(MIN_MAX), up, dn);
                default: state_next = RUN;
            endcase
        end
    end

endmodule
